// File: rtl/led_fade_pkg.sv
// led_fade_pkg
// Shared types and constants for the RGB fade/PWM peripheral.
//   fade_state_t     : fade sequencer state (IDLE, FADING)
//   NUM_CHANNELS     : number of colour channels (red, green, blue)
//   PWM_BITS_DEFAULT : default duty / PWM counter width
package led_fade_pkg;

    localparam int NUM_CHANNELS     = 3;
    localparam int PWM_BITS_DEFAULT = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        FADING = 1'b1
    } fade_state_t;

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel
// One colour channel: fade position (current), duty in use (shadow) and the
// registered PWM compare output.
// Ports:
//   clk, reset   : system clock, async active-high reset
//   pwm_cnt      : shared PWM counter value
//   wrap         : counter wraps to 0 at this edge; shadow takes current
//   target       : latched target duty for this channel
//   target_new   : target on the register bus (valid with update)
//   jump         : load current straight from target_new (fade rate 0)
//   step         : move current one step toward target
//   equal        : current == target
//   differs_new  : target_new != current
//   pin          : registered PWM output, active-high
module pwm_channel
    import led_fade_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                wrap,
    input  logic [PWM_BITS-1:0] target,
    input  logic [PWM_BITS-1:0] target_new,
    input  logic                jump,
    input  logic                step,
    output logic                equal,
    output logic                differs_new,
    output logic                pin
);

    logic [PWM_BITS-1:0] current;
    logic [PWM_BITS-1:0] shadow;

    assign equal       = (current == target);
    assign differs_new = (target_new != current);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            current <= '0;
            shadow  <= '0;
            pin     <= 1'b0;
        end else begin
            if (jump) begin
                current <= target_new;
            end else if (step && !equal) begin
                // Move by one toward the target; the !equal guard keeps it
                // from ever overshooting or wrapping.
                if (current < target)
                    current <= current + PWM_BITS'(1);
                else
                    current <= current - PWM_BITS'(1);
            end
            // Shadow only changes at the period boundary, so a duty change
            // never cuts a PWM period short. It takes the pre-edge current.
            if (wrap)
                shadow <= current;
            pin <= (pwm_cnt < shadow);
        end
    end

endmodule

// File: rtl/led_fade_pwm.sv
// led_fade_pwm
// Memory-mapped RGB fade/PWM peripheral. Software writes target colour and
// fade rate; each channel's duty then ramps one step per fade_rate PWM
// periods toward its target, with duty changes applied at period boundaries.
// Ports:
//   clk, reset                          : system clock, async active-high reset
//   update                              : one-cycle write strobe
//   target_red/green/blue               : target duties, sampled on update
//   fade_rate                           : PWM periods per duty step, 0 = jump
//   red, green, blue                    : registered PWM outputs
//   busy                                : a fade is in progress
//   done                                : one-cycle pulse when a fade ends
//   period_start                        : one-cycle pulse after counter wrap
module led_fade_pwm
    import led_fade_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEFAULT,
    parameter int PRESCALE = 47
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                update,
    input  logic [PWM_BITS-1:0] target_red,
    input  logic [PWM_BITS-1:0] target_green,
    input  logic [PWM_BITS-1:0] target_blue,
    input  logic [7:0]          fade_rate,
    output logic                red,
    output logic                green,
    output logic                blue,
    output logic                busy,
    output logic                done,
    output logic                period_start
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]     pre_cnt;
    logic                step_tick;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                wrap;

    fade_state_t         state;
    logic [7:0]          rate_reg;
    logic [7:0]          fade_cnt;
    logic [PWM_BITS-1:0] target_reg [NUM_CHANNELS];
    logic [PWM_BITS-1:0] target_in  [NUM_CHANNELS];

    logic [NUM_CHANNELS-1:0] ch_equal;
    logic [NUM_CHANNELS-1:0] ch_differs_new;
    logic [NUM_CHANNELS-1:0] ch_pin;

    logic all_equal;
    logic any_differs_new;
    logic jump;
    logic step_en;

    assign target_in[0] = target_red;
    assign target_in[1] = target_green;
    assign target_in[2] = target_blue;

    assign step_tick = (pre_cnt == PS_W'(PRESCALE - 1));
    assign wrap      = step_tick && (pwm_cnt == {PWM_BITS{1'b1}});

    assign all_equal       = &ch_equal;
    assign any_differs_new = |ch_differs_new;
    assign jump            = update && (fade_rate == 8'd0);

    // A write in the same cycle owns fade_cnt and the targets, so no step is
    // taken toward a target that is about to be replaced.
    assign step_en = (state == FADING) && !update && !all_equal && wrap &&
                     (fade_cnt == rate_reg - 8'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt      <= '0;
            pwm_cnt      <= '0;
            period_start <= 1'b0;
        end else begin
            if (step_tick) begin
                pre_cnt <= '0;
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            end else begin
                pre_cnt <= pre_cnt + PS_W'(1);
            end
            period_start <= wrap;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rate_reg <= '0;
            fade_cnt <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++)
                target_reg[i] <= '0;
        end else begin
            done <= 1'b0;
            if (update) begin
                for (int i = 0; i < NUM_CHANNELS; i++)
                    target_reg[i] <= target_in[i];
                rate_reg <= fade_rate;
                fade_cnt <= '0;
                // A rate-0 write jumps current directly, so it never starts
                // a fade from IDLE; while FADING the state is kept and the
                // fade closes out (with done) once everything matches.
                if (fade_rate != 8'd0 && any_differs_new) begin
                    state <= FADING;
                    busy  <= 1'b1;
                end
            end else if (state == FADING) begin
                if (all_equal) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else if (wrap) begin
                    if (fade_cnt == rate_reg - 8'd1)
                        fade_cnt <= '0;
                    else
                        fade_cnt <= fade_cnt + 8'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
        pwm_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .pwm_cnt     (pwm_cnt),
            .wrap        (wrap),
            .target      (target_reg[g]),
            .target_new  (target_in[g]),
            .jump        (jump),
            .step        (step_en),
            .equal       (ch_equal[g]),
            .differs_new (ch_differs_new[g]),
            .pin         (ch_pin[g])
        );
    end

    assign red   = ch_pin[0];
    assign green = ch_pin[1];
    assign blue  = ch_pin[2];

endmodule

// File: tb/tb_led_fade_pwm.sv
// tb_led_fade_pwm
// Self-checking bench for led_fade_pwm (PWM_BITS=8, PRESCALE=1). A
// behavioural model tracks counter position from elapsed cycles, the duty
// in use per period and the fade position; every cycle the DUT outputs are
// compared against it. Directed scenarios add literal expectations.
module tb_led_fade_pwm;

    localparam int B    = 8;
    localparam int PS   = 1;
    localparam int NSTP = 256;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       update = 1'b0;
    logic [7:0] t_r = 8'd0, t_g = 8'd0, t_b = 8'd0, rate = 8'd0;
    logic       red, green, blue, busy, done, period_start;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    led_fade_pwm #(.PWM_BITS(B), .PRESCALE(PS)) dut (
        .clk          (clk),
        .reset        (reset),
        .update       (update),
        .target_red   (t_r),
        .target_green (t_g),
        .target_blue  (t_b),
        .fade_rate    (rate),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .busy         (busy),
        .done         (done),
        .period_start (period_start)
    );

    // ---------------- behavioural model ----------------
    int m_k = 0;
    int m_cur[3], m_use[3], m_tgt[3], m_in[3];
    int m_rate = 0, m_periods = 0;
    bit m_fading = 1'b0;
    bit [2:0] e_pin = 3'b0;
    bit e_busy = 1'b0, e_done = 1'b0, e_ps = 1'b0;
    int m_pos;
    bit m_wrap, m_alleq, m_anydiff;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_k = 0; m_rate = 0; m_periods = 0; m_fading = 1'b0;
            for (int c = 0; c < 3; c++) begin
                m_cur[c] = 0; m_use[c] = 0; m_tgt[c] = 0;
            end
            e_pin = 3'b0; e_busy = 1'b0; e_done = 1'b0; e_ps = 1'b0;
        end else begin
            m_pos  = (m_k / PS) % NSTP;
            m_wrap = ((m_k % PS) == PS - 1) && (m_pos == NSTP - 1);
            m_k++;
            m_in[0] = t_r; m_in[1] = t_g; m_in[2] = t_b;
            for (int c = 0; c < 3; c++)
                e_pin[2-c] = (m_pos < m_use[c]);
            e_ps = m_wrap;
            if (m_wrap)
                for (int c = 0; c < 3; c++) m_use[c] = m_cur[c];
            e_done = 1'b0;
            m_alleq = 1'b1;
            m_anydiff = 1'b0;
            for (int c = 0; c < 3; c++) begin
                if (m_cur[c] != m_tgt[c]) m_alleq = 1'b0;
                if (m_cur[c] != m_in[c]) m_anydiff = 1'b1;
            end
            if (update) begin
                for (int c = 0; c < 3; c++) m_tgt[c] = m_in[c];
                m_rate = rate;
                m_periods = 0;
                if (rate == 0)
                    for (int c = 0; c < 3; c++) m_cur[c] = m_in[c];
                else if (m_anydiff)
                    m_fading = 1'b1;
            end else if (m_fading) begin
                if (m_alleq) begin
                    m_fading = 1'b0;
                    e_done = 1'b1;
                end else if (m_wrap) begin
                    m_periods++;
                    if (m_periods == m_rate) begin
                        m_periods = 0;
                        for (int c = 0; c < 3; c++) begin
                            if (m_cur[c] < m_tgt[c]) m_cur[c]++;
                            else if (m_cur[c] > m_tgt[c]) m_cur[c]--;
                        end
                    end
                end
            end
            e_busy = m_fading;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if ({red, green, blue, busy, done, period_start} !==
                {e_pin, e_busy, e_done, e_ps}) begin
                failures++;
                $display("FAIL cycle_compare t=%0t dut rgb/busy/done/ps=%b model=%b",
                         $time, {red, green, blue, busy, done, period_start},
                         {e_pin, e_busy, e_done, e_ps});
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (done === 1'b1) done_cnt++;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_update(input int r, input int g, input int b, input int rt);
        t_r = 8'(r); t_g = 8'(g); t_b = 8'(b); rate = 8'(rt);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic wait_ps(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (period_start) begin ok = 1'b1; break; end
        end
        if (!ok) chk({name, "_ps_timeout"}, 0, 1);
    endtask

    task automatic align();
        wait_ps("align");
        cyc(10);
    endtask

    // Counts high cycles over one full period with a stable duty.
    task automatic measure(output int hr, output int hg, output int hb);
        hr = 0; hg = 0; hb = 0;
        wait_ps("measure");
        for (int i = 0; i < NSTP; i++) begin
            @(negedge clk);
            if (red) hr++;
            if (green) hg++;
            if (blue) hb++;
        end
    endtask

    // Waits for busy to fall; returns wraps seen while busy.
    task automatic wait_idle(input string name, output int periods);
        bit ok = 1'b0;
        periods = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (period_start && busy) periods++;
            if (!busy) begin ok = 1'b1; break; end
        end
        chk({name, "_finished"}, int'(ok), 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hr, hg, hb, np, d0, hi_cnt;
        bit ok;

        cyc(2);
        cmp_en = 1'b1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_ps", period_start, 0);
        chk("reset_pins", {red, green, blue}, 0);
        reset = 1'b0;
        cyc(3);

        // 1: immediate set
        d0 = done_cnt;
        do_update(64, 0, 255, 0);
        chk("imm_busy_t1", busy, 0);
        measure(hr, hg, hb);
        chk("imm_red_high", hr, 64);
        chk("imm_green_high", hg, 0);
        chk("imm_blue_high", hb, 255);
        chk("imm_no_done", done_cnt - d0, 0);

        // 2: fade up from 0 to 4 at two periods per step
        do_update(0, 0, 0, 0);
        align();
        d0 = done_cnt;
        do_update(4, 0, 0, 2);
        chk("fade_busy_t1", busy, 1);
        wait_idle("fade_up", np);
        chk("fade_up_periods", np, 8);
        chk("fade_up_done", done_cnt - d0, 1);
        measure(hr, hg, hb);
        chk("fade_up_duty", hr, 4);

        // 3: retarget mid-fade
        do_update(0, 0, 0, 0);
        align();
        d0 = done_cnt;
        do_update(4, 0, 0, 1);
        np = 0;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (period_start) np++;
            if (np == 3) begin ok = 1'b1; break; end
        end
        chk("retarget_reach3", int'(ok), 1);
        cyc(20);
        do_update(1, 0, 0, 1);
        wait_idle("retarget", np);
        chk("retarget_periods", np, 2);
        chk("retarget_done", done_cnt - d0, 1);
        measure(hr, hg, hb);
        chk("retarget_duty", hr, 1);

        // 4: glitch-free duty change at counter 100
        do_update(200, 0, 0, 0);
        measure(hr, hg, hb);
        chk("glitch_pre", hr, 200);
        wait_ps("glitch");
        hr = 0;
        for (int i = 0; i < NSTP; i++) begin
            @(negedge clk);
            if (red) hr++;
            if (i == 99) begin t_r = 8'd10; rate = 8'd0; update = 1'b1; end
            if (i == 100) update = 1'b0;
        end
        chk("glitch_same_period", hr, 200);
        hr = 0;
        for (int i = 0; i < NSTP; i++) begin
            @(negedge clk);
            if (red) hr++;
        end
        chk("glitch_next_period", hr, 10);

        // 5: async reset mid-fade
        align();
        do_update(255, 128, 60, 1);
        cyc(300);
        chk("rst_busy_before", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_pins", {red, green, blue}, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_ps", period_start, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        hi_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (red || green || blue || busy) hi_cnt++;
        end
        chk("rst_stays_low", hi_cnt, 0);

        // 6: no-op update in IDLE
        align();
        d0 = done_cnt;
        do_update(0, 0, 0, 3);
        chk("noop_busy_t1", busy, 0);
        cyc(300);
        chk("noop_busy", busy, 0);
        chk("noop_done", done_cnt - d0, 0);

        // random traffic against the model
        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end else begin
                do_update($urandom_range(0, 255), $urandom_range(0, 255),
                          $urandom_range(0, 255), $urandom_range(0, 3));
            end
            cyc($urandom_range(5, 2500));
        end
        cyc(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
